// File: rtl/byte_packer.sv
// byte_packer: packs an 8-bit valid/ready byte stream into little-endian
// words of BYTES_PER_WORD bytes with a byte-keep mask and explicit flush.
// Ports: clk, rst_n (async, active-low); in_data/in_valid/in_ready byte side;
// flush (single-cycle partial-word request); out_data/out_keep/out_valid/
// out_ready word side; out_parity per-byte even parity (only when the
// BYTE_PACKER_PARITY_EN macro is defined).
module byte_packer #(
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [8*BYTES_PER_WORD-1:0] out_data,
    output logic [BYTES_PER_WORD-1:0]   out_keep,
    output logic                        out_valid,
`ifdef BYTE_PACKER_PARITY_EN
    output logic [BYTES_PER_WORD-1:0]   out_parity,
`endif
    input  logic                        out_ready
);

    localparam int W  = 8 * BYTES_PER_WORD;
    localparam int CW = $clog2(BYTES_PER_WORD);
    localparam int KW = CW + 1;
    localparam logic [CW-1:0] LAST = CW'(BYTES_PER_WORD - 1);

    typedef enum logic {
        FILL,
        FLUSH_WAIT
    } state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [W-1:0]              acc;

    logic                      slot_free;
    logic                      last;
    logic                      take;
    logic                      full;
    logic [KW-1:0]             eff;
    logic [W-1:0]              acc_nxt;
    logic [BYTES_PER_WORD-1:0] keep_nxt;
    logic                      load;
`ifdef BYTE_PACKER_PARITY_EN
    logic [BYTES_PER_WORD-1:0] par_nxt;
`endif

    always_comb begin
        slot_free = !out_valid || out_ready;
        last      = (cnt == LAST);
        in_ready  = (state == FILL) && (!last || slot_free);
        take      = in_valid && in_ready;
        full      = take && last;
        // Effective fill counts a byte accepted in the same cycle.
        eff       = {1'b0, cnt} + {{CW{1'b0}}, take};
        acc_nxt   = acc;
        keep_nxt  = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (take && cnt == CW'(k))
                acc_nxt[8*k +: 8] = in_data;
            // eff == BYTES_PER_WORD yields all ones for a full word.
            keep_nxt[k] = (KW'(k) < eff);
        end
        if (state == FILL)
            load = full || (flush && eff != '0 && slot_free);
        else
            load = slot_free;
`ifdef BYTE_PACKER_PARITY_EN
        par_nxt = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++)
            par_nxt[k] = ^acc_nxt[8*k +: 8];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
`ifdef BYTE_PACKER_PARITY_EN
            out_parity <= '0;
`endif
        end else begin
            if (out_ready)
                out_valid <= 1'b0;
            if (load) begin
                // Unused lanes of acc are zero, so partial words are clean.
                out_valid <= 1'b1;
                out_data  <= acc_nxt;
                out_keep  <= keep_nxt;
`ifdef BYTE_PACKER_PARITY_EN
                out_parity <= par_nxt;
`endif
            end
            unique case (state)
                FILL: begin
                    if (load) begin
                        acc <= '0;
                        cnt <= '0;
                    end else if (flush && eff != '0 && !full) begin
                        // Slot occupied: park the partial word in acc.
                        acc   <= acc_nxt;
                        cnt   <= eff[CW-1:0];
                        state <= FLUSH_WAIT;
                    end else if (take) begin
                        acc <= acc_nxt;
                        cnt <= cnt + CW'(1);
                    end
                end
                FLUSH_WAIT: begin
                    if (load) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_packer.sv
// Scoreboard bench for byte_packer: randomized and directed stimulus against
// a queue-based byte/word reference model.
module tb_byte_packer;

    localparam int BPW = 4;
    localparam int W   = 8 * BPW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           flush = 1'b0;
    logic [W-1:0]   out_data;
    logic [BPW-1:0] out_keep;
    logic           out_valid;
    logic           out_ready = 1'b0;
`ifdef BYTE_PACKER_PARITY_EN
    logic [BPW-1:0] out_parity;
`endif

    byte_packer #(.BYTES_PER_WORD(BPW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .out_data(out_data),
        .out_keep(out_keep),
        .out_valid(out_valid),
`ifdef BYTE_PACKER_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   d;
        logic [BPW-1:0] k;
    } word_t;

    word_t      expq[$];
    logic [7:0] bytes[$];
    int checks = 0;
    int failures = 0;
    int words_seen = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: collect accepted bytes; a full set or an honoured flush
    // forms the next expected word in order.
    task automatic emit_model();
        word_t w;
        w.d = '0;
        w.k = '0;
        for (int i = 0; i < bytes.size(); i++) begin
            w.d[8*i +: 8] = bytes[i];
            w.k[i] = 1'b1;
        end
        expq.push_back(w);
        bytes.delete();
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic f,
                         input logic ordy, output logic took);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = ordy;
        #1;
        took = v && in_ready;
        if (took) begin
            bytes.push_back(d);
            if (bytes.size() == BPW)
                emit_model();
        end
        if (f && bytes.size() > 0)
            emit_model();
    endtask

    task automatic idle(input int n);
        logic t;
        for (int i = 0; i < n; i++)
            cycle(1'b0, 8'h00, 1'b0, 1'b1, t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        expq.delete();
        bytes.delete();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_keep", 64'(out_keep), 64'd0);
`ifdef BYTE_PACKER_PARITY_EN
        chk("rst_out_parity", 64'(out_parity), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    // Monitor: pops on every word transfer; also checks hold under stall.
    logic         prev_stall = 1'b0;
    logic [W-1:0] held_d;
    logic [BPW-1:0] held_k;
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_data", 64'(out_data), 64'(held_d));
                    chk("hold_keep", 64'(out_keep), 64'(held_k));
                end
                if (out_valid && out_ready) begin
                    words_seen++;
                    checks++;
                    if (expq.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_word actual=%0h required=none",
                                 out_data);
                    end else begin
                        checks--;
                        w = expq.pop_front();
                        chk("word_data", 64'(out_data), 64'(w.d));
                        chk("word_keep", 64'(out_keep), 64'(w.k));
`ifdef BYTE_PACKER_PARITY_EN
                        begin
                            logic [BPW-1:0] p;
                            for (int k = 0; k < BPW; k++)
                                p[k] = ^w.d[8*k +: 8];
                            chk("word_parity", 64'(out_parity), 64'(p));
                        end
`endif
                    end
                end
                prev_stall = out_valid && !out_ready;
                held_d = out_data;
                held_k = out_keep;
            end
        end
    end

    initial begin
        logic t;
        int n;
        int ws;
        do_reset();

        // Basic word and latency.
        cycle(1'b1, 8'h11, 1'b0, 1'b1, t);
        cycle(1'b1, 8'h22, 1'b0, 1'b1, t);
        cycle(1'b1, 8'h33, 1'b0, 1'b1, t);
        cycle(1'b1, 8'h44, 1'b0, 1'b1, t);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, t);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_data", 64'(out_data), 64'h44332211);
        chk("lat_keep", 64'(out_keep), 64'hf);
        idle(2);

        // Twelve back-to-back bytes, no stalls.
        ws = words_seen;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b1, t);
            if (!t) n++;
        end
        chk("stream_stalls", 64'(n), 64'd0);
        idle(3);
        chk("stream_words", 64'(words_seen - ws), 64'd3);

        // Flush after two bytes, then a fresh word at lane 0.
        cycle(1'b1, 8'hAA, 1'b0, 1'b1, t);
        cycle(1'b1, 8'hBB, 1'b0, 1'b1, t);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, t);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, t);
        chk("flush_data", 64'(out_data), 64'h0000BBAA);
        chk("flush_keep", 64'(out_keep), 64'h3);
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 8'(i), 1'b0, 1'b1, t);
        // Flush in the same cycle as a byte.
        cycle(1'b1, 8'hAA, 1'b0, 1'b1, t);
        cycle(1'b1, 8'hBB, 1'b0, 1'b1, t);
        cycle(1'b1, 8'hCC, 1'b1, 1'b1, t);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, t);
        chk("flush_byte_keep", 64'(out_keep), 64'h7);
        idle(3);

        // Back-pressure: slot full, then exactly three more bytes.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, t);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, t);
            if (t) n++;
        end
        chk("bp_accepted", 64'(n), 64'd3);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        n = 0;
        t = 1'b0;
        while (!t && n < 10) begin
            cycle(1'b1, 8'h7F, 1'b0, 1'b1, t);
            n++;
        end
        chk("bp_resume", 64'(t), 64'd1);
        idle(3);

        // Flush with slot full waits, then emits.
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, t);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, t);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h99, 1'(i == 1), 1'b0, t);
            chk("fw_blocked", 64'(t), 64'd0);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, t);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, t);
        chk("fw_in_ready", 64'(in_ready), 64'd1);
        chk("fw_keep", 64'(out_keep), 64'h3);
        chk("fw_data", 64'(out_data), 64'h00008584);
        idle(2);
        // Flush with nothing buffered.
        ws = words_seen;
        cycle(1'b0, 8'h00, 1'b1, 1'b1, t);
        idle(3);
        chk("flush_empty", 64'(words_seen - ws), 64'd0);

        // Reset mid-word discards partial bytes.
        cycle(1'b1, 8'hE1, 1'b0, 1'b1, t);
        cycle(1'b1, 8'hE2, 1'b0, 1'b1, t);
        ws = words_seen;
        do_reset();
        idle(3);
        chk("rst_no_word", 64'(words_seen - ws), 64'd0);
        cycle(1'b1, 8'h07, 1'b0, 1'b1, t);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 8'h00, 1'b0, 1'b1, t);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, t);
        chk("post_rst_data", 64'(out_data), 64'h00000007);
`ifdef BYTE_PACKER_PARITY_EN
        chk("parity_lane0", 64'(out_parity[0]), 64'd1);
`endif
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 3) != 0), t);

        // Drain with a bounded wait, flushing the tail.
        cycle(1'b0, 8'h00, 1'b1, 1'b1, t);
        n = 0;
        while (expq.size() != 0 && n < 50) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1, t);
            n++;
        end
        idle(2);
        chk("drain_left", 64'(expq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_packer.md
# byte_packer

Downstream stage of the 8-bit valid/ready byte producer: accepts the byte stream and packs consecutive bytes into wide words for a word-oriented consumer. Supports an explicit flush that emits a partially filled word with a byte-keep mask. Sustains one byte per cycle while the word consumer keeps up.

## Interface
- BYTES_PER_WORD, 4, bytes per output word; legal range 2..8
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- in_data  input  8  byte from producer
- in_valid  input  1  in_data valid
- in_ready  output  1  packer can accept a byte this cycle
- flush  input  1  single-cycle request to emit the current partial word
- out_data  output  8*BYTES_PER_WORD  packed word; byte k at bits [8k+7:8k]
- out_keep  output  BYTES_PER_WORD  bit k set = byte k meaningful
- out_valid  output  1  out_data/out_keep valid
- out_ready  input  1  consumer accepts word
- out_parity  output  BYTES_PER_WORD  per-byte even parity (only with BYTE_PACKER_PARITY_EN)

## Operation
- Byte transfer when in_valid && in_ready; word transfer when out_valid && out_ready.
- Accumulator acc plus fill counter cnt (0..BYTES_PER_WORD-1); accepted byte written to acc lane cnt; first byte lands in lane 0 (little-endian).
- Byte accepted with cnt == BYTES_PER_WORD-1: acc + byte loaded into output register, out_keep all ones, cnt -> 0.
- Output register is a single slot; slot_free = !out_valid || out_ready.
- in_ready = !flush_pend && (cnt != BYTES_PER_WORD-1 || slot_free).
- FSM states: FILL (normal), FLUSH_WAIT (flush_pend = 1).
- flush in FILL, effective fill (cnt plus byte accepted same cycle) > 0 and < BYTES_PER_WORD: if slot_free, load partial word next cycle, keep = low effective-fill bits set, unused lanes zero, cnt -> 0; else go to FLUSH_WAIT.
- FLUSH_WAIT: in_ready = 0; when slot_free, load partial word, return to FILL.
- flush with effective fill 0, or same cycle a byte completes a full word: ignored (full word emitted normally).
- flush while in FLUSH_WAIT: ignored.
- out_data/out_keep/out_parity held stable while out_valid && !out_ready.
- Reset: out_valid 0, out_data 0, out_keep 0, out_parity 0, cnt 0, acc 0, state FILL; in_ready 1 once rst_n released. Reset mid-word discards partial bytes with no output.

## Timing
- Latency: byte completing a word at edge t -> out_valid high after edge t (visible cycle t+1).
- Flush with free slot: partial word valid the cycle after flush.
- Throughput: one byte/cycle, one word every BYTES_PER_WORD cycles with out_ready held high; no bubble on word boundaries.
- in_ready is combinational from cnt, flush_pend, out_valid, out_ready; no combinational path in_valid -> in_ready or out_ready -> out_valid.
- Back-pressure: with out_ready low and slot full, at most BYTES_PER_WORD-1 further bytes accepted, then in_ready low.

## Configuration
- BYTE_PACKER_PARITY_EN defined: out_parity[k] = ^out_data[8k+7:8k], registered with out_data; zero on unkept lanes.
- Undefined: out_parity port absent, no parity logic.

## Test plan
- Reset, BYTES_PER_WORD=4, bytes 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 -> one word 0x44332211, keep 4'b1111, out_valid one cycle after 0x44 accepted.
- 12 consecutive bytes, out_ready=1 -> three words, in_ready never low, no idle cycles.
- Bytes 0xAA,0xBB then flush -> word 0x0000BBAA, keep 4'b0011; following bytes start a fresh word at lane 0.
- out_ready=0 with slot full, stream bytes -> exactly 3 accepted then in_ready low; raise out_ready -> stalled word drained, next word correct.
- Flush while slot full and out_ready=0 -> in_ready low (FLUSH_WAIT) until out_ready, then partial word emitted; flush with cnt 0 -> no output.
- rst_n pulsed after 2 bytes -> all outputs 0, no word emitted; with PARITY_EN, byte 0x07 -> out_parity[0]=1.
